// File: rtl/twos_comp_pkg.sv
// twos_comp_pkg: FSM state encoding and default word width shared by the serial two's-complement block
package twos_comp_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/serial_twos_comp_core.sv
// serial_twos_comp_core: bit-serial negation, copies bits up to and including the first 1, inverts the rest
// ports: clk, reset (async high), clr (restart word), en (consume din), din (LSB-first), dout (negated bit)
module serial_twos_comp_core (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic dout
);
  logic seen_one_q, seen_one_d;
  always_comb seen_one_d = clr ? 1'b0 : en ? (seen_one_q | din) : seen_one_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) seen_one_q <= 1'b0;
    else       seen_one_q <= seen_one_d;
  end
  assign dout = din ^ seen_one_q;
endmodule

// File: rtl/twos_comp_serial_ctrl.sv
// twos_comp_serial_ctrl: takes a word over valid/ready, negates it LSB-first through the serial core, returns it over valid/ready
// ports: clk, reset (async high); in_valid/in_data/in_ready operand side; out_valid/out_data/out_zero/out_ovf/out_ready result side; busy = not idle
module twos_comp_serial_ctrl
  import twos_comp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ovf,
  input  logic             out_ready,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, result_q, result_d, out_data_q, out_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic out_valid_q, out_valid_d, zero_q, zero_d, ovf_q, ovf_d;
  logic accept, shifting, last, obit;
  assign accept   = in_valid && state_q == S_IDLE;
  assign shifting = state_q == S_SHIFT;
  assign last     = cnt_q == CW'(WIDTH - 1);
  serial_twos_comp_core u_core (
    .clk  (clk),
    .reset(reset),
    .clr  (accept),
    .en   (shifting),
    .din  (sreg_q[0]),
    .dout (obit)
  );
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    result_d    = result_q;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: if (accept) begin
        sreg_d  = in_data;
        zero_d  = in_data == '0;
        ovf_d   = in_data == {1'b1, {(WIDTH-1){1'b0}}};
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        sreg_d   = sreg_q >> 1;
        result_d = {obit, result_q[WIDTH-1:1]};
        cnt_d    = last ? cnt_q : cnt_q + 1'b1;
        if (last) begin
          out_data_d  = result_d;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      result_q    <= '0;
      out_data_q  <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      result_q    <= result_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end
  assign in_ready  = state_q == S_IDLE;
  assign busy      = state_q != S_IDLE;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_zero  = zero_q;
  assign out_ovf   = ovf_q;
endmodule
